ones_frame_stats: RTL and testbench

Downstream consumer of the 16-bit ones counter (`count1`): it accepts one 5-bit per-word ones count per cycle under a valid strobe. Over fixed frames of `FRAME_LEN` words it accumulates the total ones, the maximum and minimum per-word count, and the number of "dense" words (count > `THRESH`). Each completed frame's statistics are presented on a valid/ready output port, so a control or logging stage can consume them without stalling the counter.

---
 rtl/ones_frame_stats_if.sv | 74 +++++++
 rtl/ones_frame_stats.sv | 231 +++++++++++++++++++++++
 tb/tb_ones_frame_stats.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ones_frame_stats_if.sv
// ----------------------------------------------------------------------------
// ones_frame_stats_if
//
// Purpose: bundles the word input, the frame-result output and the status
// flags of ones_frame_stats so that producer/consumer and the block itself
// connect through one port.
//
// Signals:
//   clear        producer -> block   synchronous abort of the frame in progress
//   in_valid     producer -> block   in_ones carries a word count this cycle
//   in_ones[4:0] producer -> block   per-word ones count (legal 0..16)
//   out_ready    consumer -> block   consumer accepts the held result
//   out_valid    block -> consumer   a frame result is held on frame_*
//   frame_total  block -> consumer   sum of counts over the frame
//   frame_max    block -> consumer   largest count in the frame
//   frame_min    block -> consumer   smallest count in the frame
//   frame_dense  block -> consumer   number of dense words in the frame
//   overrun      block -> consumer   sticky: a completed frame was dropped
//   range_err    block -> consumer   sticky: an in_ones value > 16 was seen
//
// Handshake semantics:
//   Input side has no backpressure: every rising edge with in_valid=1 (and
//   clear=0) accepts one word. Output side is valid/ready: once out_valid
//   rises, frame_* stay stable until the edge where out_valid && out_ready
//   are both 1; that edge consumes the result. out_ready is ignored while
//   out_valid=0, and out_valid never depends combinationally on out_ready.
//
// Modports:
//   master  producer/consumer side (drives inputs, observes results)
//   slave   ones_frame_stats side
// ----------------------------------------------------------------------------
interface ones_frame_stats_if #(
    parameter int TOTAL_W = 7
);
    logic               clear;
    logic               in_valid;
    logic [4:0]         in_ones;
    logic               out_ready;
    logic               out_valid;
    logic [TOTAL_W-1:0] frame_total;
    logic [4:0]         frame_max;
    logic [4:0]         frame_min;
    logic [7:0]         frame_dense;
    logic               overrun;
    logic               range_err;

    modport master (
        output clear,
        output in_valid,
        output in_ones,
        output out_ready,
        input  out_valid,
        input  frame_total,
        input  frame_max,
        input  frame_min,
        input  frame_dense,
        input  overrun,
        input  range_err
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  in_ones,
        input  out_ready,
        output out_valid,
        output frame_total,
        output frame_max,
        output frame_min,
        output frame_dense,
        output overrun,
        output range_err
    );
endinterface

// File: rtl/ones_frame_stats.sv
// ----------------------------------------------------------------------------
// ones_frame_stats
//
// Purpose: accumulates per-frame statistics (total ones, max, min, number of
// dense words) over fixed frames of FRAME_LEN word counts and presents each
// completed frame on a one-deep valid/ready output register.
//
// Parameters:
//   FRAME_LEN  words per frame (2..255)
//   THRESH     a word is dense when its count is strictly greater (0..15)
//   TOTAL_W    total-sum width, ceil(log2(16*FRAME_LEN+1))
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          ones_frame_stats_if.slave (word input, frame output, flags)
//   dbg_state_o  output register state (0 = EMPTY, 1 = FULL)
// ----------------------------------------------------------------------------
module ones_frame_stats #(
    parameter int FRAME_LEN = 4,
    parameter int THRESH    = 8,
    parameter int TOTAL_W   = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ones_frame_stats_if.slave       bus,
    output logic                    dbg_state_o
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [4:0] THRESH_V = 5'(THRESH);
    localparam logic [4:0] MAX_ONES = 5'd16;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    // ------------------------------------------------------------------
    // Accumulator and output state
    // ------------------------------------------------------------------
    logic [TOTAL_W-1:0] acc_total_q, acc_total_d;
    logic [4:0]         acc_max_q,   acc_max_d;
    logic [4:0]         acc_min_q,   acc_min_d;
    logic [7:0]         acc_dense_q, acc_dense_d;
    logic [7:0]         word_cnt_q,  word_cnt_d;

    out_state_e         state_q, state_d;
    logic [TOTAL_W-1:0] out_total_q, out_total_d;
    logic [4:0]         out_max_q,   out_max_d;
    logic [4:0]         out_min_q,   out_min_d;
    logic [7:0]         out_dense_q, out_dense_d;
    logic               overrun_q,   overrun_d;
    logic               range_err_q, range_err_d;

    // ------------------------------------------------------------------
    // Per-word datapath
    // ------------------------------------------------------------------
    logic               in_over;     // raw count above the legal 16
    logic [4:0]         value;       // saturated count actually used
    logic               accept;      // a word enters the accumulators
    logic               is_first;
    logic               is_last;
    logic               is_dense;
    logic               complete;    // this accepted word closes a frame
    logic               load_out;    // output register captures the frame

    // Statistics including the current word; these feed both the
    // accumulators and, on completion, the output register.
    logic [TOTAL_W-1:0] stat_total;
    logic [4:0]         stat_max;
    logic [4:0]         stat_min;
    logic [7:0]         stat_dense;

    always_comb begin
        in_over  = bus.in_ones > MAX_ONES;
        value    = in_over ? MAX_ONES : bus.in_ones;
        accept   = bus.in_valid && !bus.clear;
        is_first = (word_cnt_q == 8'd0);
        is_last  = (word_cnt_q == LAST_IDX);
        is_dense = (value > THRESH_V);
        complete = accept && is_last;
    end

    // The first word of a frame restarts every statistic, so leftovers from
    // the previous frame never need an explicit clearing cycle.
    always_comb begin
        stat_total = TOTAL_W'(value);
        stat_max   = value;
        stat_min   = value;
        stat_dense = {7'd0, is_dense};
        if (!is_first) begin
            stat_total = acc_total_q + TOTAL_W'(value);
            stat_max   = (value > acc_max_q) ? value : acc_max_q;
            stat_min   = (value < acc_min_q) ? value : acc_min_q;
            stat_dense = acc_dense_q + {7'd0, is_dense};
        end
    end

    // ------------------------------------------------------------------
    // Accumulator next state
    // ------------------------------------------------------------------
    always_comb begin
        acc_total_d = acc_total_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        acc_dense_d = acc_dense_q;
        word_cnt_d  = word_cnt_q;
        range_err_d = range_err_q;

        if (bus.clear) begin
            // Abort: the word presented this cycle (if any) is dropped too.
            acc_total_d = '0;
            acc_max_d   = '0;
            acc_min_d   = '0;
            acc_dense_d = '0;
            word_cnt_d  = '0;
        end else if (bus.in_valid) begin
            acc_total_d = stat_total;
            acc_max_d   = stat_max;
            acc_min_d   = stat_min;
            acc_dense_d = stat_dense;
            word_cnt_d  = is_last ? 8'd0 : word_cnt_q + 8'd1;
            if (in_over) begin
                range_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_total_q <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= '0;
            acc_dense_q <= '0;
            word_cnt_q  <= '0;
            range_err_q <= 1'b0;
        end else begin
            acc_total_q <= acc_total_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            acc_dense_q <= acc_dense_d;
            word_cnt_q  <= word_cnt_d;
            range_err_q <= range_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            S_EMPTY: begin
                if (complete) begin
                    load_out = 1'b1;
                    state_d  = S_FULL;
                end
            end
            S_FULL: begin
                if (complete) begin
                    // A result consumed on the same edge frees the slot for
                    // the new frame; otherwise the new frame is lost.
                    if (bus.out_ready) begin
                        load_out = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (bus.out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_comb begin
        out_total_d = out_total_q;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;
        out_dense_d = out_dense_q;
        if (load_out) begin
            out_total_d = stat_total;
            out_max_d   = stat_max;
            out_min_d   = stat_min;
            out_dense_d = stat_dense;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_total_q <= '0;
            out_max_q   <= '0;
            out_min_q   <= MAX_ONES;
            out_dense_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            out_total_q <= out_total_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_dense_q <= out_dense_d;
            overrun_q   <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_valid   = (state_q == S_FULL);
    assign bus.frame_total = out_total_q;
    assign bus.frame_max   = out_max_q;
    assign bus.frame_min   = out_min_q;
    assign bus.frame_dense = out_dense_q;
    assign bus.overrun     = overrun_q;
    assign bus.range_err   = range_err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ones_frame_stats.sv
// ----------------------------------------------------------------------------
// tb_ones_frame_stats
//
// Drives ones_frame_stats (FRAME_LEN=4, THRESH=8) with directed scenarios and
// randomized traffic, comparing every output each cycle against a reference
// model that keeps the words of the open frame in a queue and computes frame
// statistics by walking that queue when the frame closes.
// ----------------------------------------------------------------------------
module tb_ones_frame_stats;

    localparam int FRAME_LEN = 4;
    localparam int THRESH    = 8;
    localparam int TOTAL_W   = 7;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;
    logic dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ones_frame_stats_if #(.TOTAL_W(TOTAL_W)) bus ();

    ones_frame_stats #(
        .FRAME_LEN (FRAME_LEN),
        .THRESH    (THRESH),
        .TOTAL_W   (TOTAL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_q[$];          // saturated words of the open frame
    logic       m_valid;
    int         m_total;
    int         m_max;
    int         m_min;
    int         m_dense;
    logic       m_overrun;
    logic       m_range_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_valid     = 1'b0;
        m_total     = 0;
        m_max       = 0;
        m_min       = 16;
        m_dense     = 0;
        m_overrun   = 1'b0;
        m_range_err = 1'b0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_edge(input logic v, input logic [4:0] ones,
                              input logic clr, input logic rdy);
        logic done;
        int   t, mx, mn, dn;
        done = 1'b0;
        t = 0; mx = 0; mn = 99; dn = 0;
        if (clr) begin
            exp_q.delete();
        end else if (v) begin
            if (ones > 16) m_range_err = 1'b1;
            exp_q.push_back((ones > 16) ? 5'd16 : ones);
            if (exp_q.size() == FRAME_LEN) begin
                foreach (exp_q[i]) begin
                    t += int'(exp_q[i]);
                    if (int'(exp_q[i]) > mx) mx = int'(exp_q[i]);
                    if (int'(exp_q[i]) < mn) mn = int'(exp_q[i]);
                    if (int'(exp_q[i]) > THRESH) dn++;
                end
                exp_q.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_total = t;
                m_max   = mx;
                m_min   = mn;
                m_dense = dn;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("out_valid",   int'(bus.out_valid),   int'(m_valid));
        check("dbg_state",   int'(dbg_state),       int'(m_valid));
        check("frame_total", int'(bus.frame_total), m_total);
        check("frame_max",   int'(bus.frame_max),   m_max);
        check("frame_min",   int'(bus.frame_min),   m_min);
        check("frame_dense", int'(bus.frame_dense), m_dense);
        check("overrun",     int'(bus.overrun),     int'(m_overrun));
        check("range_err",   int'(bus.range_err),   int'(m_range_err));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (entered and left at a falling edge)
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic [4:0] ones,
                        input logic clr, input logic rdy);
        bus.in_valid  = v;
        bus.in_ones   = ones;
        bus.clear     = clr;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(v, ones, clr, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic word(input logic [4:0] ones, input logic rdy);
        step(1'b1, ones, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 1'b0, rdy);
    endtask

    // Reset takes effect immediately, so outputs are checked before any edge.
    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ones   = 5'd0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ones   = 5'd0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic frame with a one-cycle result.
        word(5'd16, 1'b1); word(5'd8, 1'b1); word(5'd10, 1'b1); word(5'd0, 1'b1);
        check("t1_total", int'(bus.frame_total), 34);
        check("t1_max",   int'(bus.frame_max),   16);
        check("t1_min",   int'(bus.frame_min),   0);
        check("t1_dense", int'(bus.frame_dense), 2);
        idle(1'b1);
        check("t1_consumed", int'(bus.out_valid), 0);

        // Back-to-back frames.
        for (int i = 0; i < 4; i++) word(5'd1, 1'b1);
        check("t2_total_a", int'(bus.frame_total), 4);
        for (int i = 0; i < 4; i++) word(5'd16, 1'b1);
        check("t2_total_b", int'(bus.frame_total), 64);
        check("t2_dense_b", int'(bus.frame_dense), 4);
        idle(1'b1);

        // Overrun: second frame dropped while result held.
        for (int i = 0; i < 4; i++) word(5'd5, 1'b0);
        for (int i = 0; i < 4; i++) word(5'd9, 1'b0);
        idle(1'b0); idle(1'b0);
        check("t3_held_total", int'(bus.frame_total), 20);
        check("t3_overrun",    int'(bus.overrun),     1);
        idle(1'b1);
        check("t3_drained", int'(bus.out_valid), 0);
        idle(1'b0);

        // Clear aborts the frame and the word presented with it.
        word(5'd3, 1'b1); word(5'd7, 1'b1);
        step(1'b1, 5'd12, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) word(5'd2, 1'b1);
        check("t4_total", int'(bus.frame_total), 8);
        idle(1'b1);

        // Out-of-range count saturates.
        word(5'd20, 1'b1); word(5'd0, 1'b1); word(5'd0, 1'b1); word(5'd0, 1'b1);
        check("t5_total",     int'(bus.frame_total), 16);
        check("t5_range_err", int'(bus.range_err),   1);
        idle(1'b1);

        // Reset mid-frame while a result is held.
        for (int i = 0; i < 4; i++) word(5'd11, 1'b0);
        word(5'd4, 1'b0); word(5'd4, 1'b0);
        do_reset();
        check("t6_min_reset", int'(bus.frame_min), 16);
        word(5'd6, 1'b1); word(5'd9, 1'b1); word(5'd2, 1'b1); word(5'd13, 1'b1);
        check("t6_total", int'(bus.frame_total), 30);
        idle(1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic       v, clr, rdy;
            logic [4:0] ones;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                v    = ($urandom_range(0, 3) != 0);
                ones = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31))
                                                    : 5'($urandom_range(0, 16));
                clr  = ($urandom_range(0, 39) == 0);
                rdy  = ($urandom_range(0, 9) < 6);
                step(v, ones, clr, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
